// File: rtl/sccb_req_arbiter.sv
// Round-robin arbiter that serialises 24-bit register writes from several
// requesters onto one SCCB/I2C master, with guard and soft-reset settle delays.
module sccb_req_arbiter #(
  parameter int          NUM_REQ       = 3,
  parameter logic [19:0] GUARD_CYC     = 20'd100,
  parameter logic [19:0] RESET_DLY_CYC = 20'd120000,
  parameter logic [19:0] TIMEOUT_CYC   = 20'd500000
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [24*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     ack,
  output logic [NUM_REQ-1:0]     err,
  output logic                   i2c_start,
  output logic [23:0]            i2c_data,
  input  logic                   i2c_end,
  output logic                   busy
);

  localparam int PTR_W = $clog2(NUM_REQ);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ISSUE    = 2'd1;
  localparam logic [1:0] WAIT_END = 2'd2;
  localparam logic [1:0] HOLD     = 2'd3;

  logic [1:0]         state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   winner;
  logic               win_found;
  logic [19:0]        hold_cnt;
  logic [19:0]        to_cnt;
  logic               soft_rst_wr;
  logic [23:0]        slot [NUM_REQ];
  logic [NUM_REQ-1:0] win_onehot;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
    assign slot[g] = req_data[24*g +: 24];
  end

  // A write of 0x3008 with bit 7 set is the sensor software reset and needs a long settle.
  assign soft_rst_wr = (i2c_data[23:8] == 16'h3008) && i2c_data[7];
  assign win_onehot  = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;

  // Search upward from the slot after the last winner, wrapping around.
  always_comb begin
    logic [PTR_W-1:0] idx;
    logic             hit;
    winner    = rr_ptr;
    win_found = 1'b0;
    idx       = '0;
    hit       = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx       = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
      hit       = !win_found && req[idx];
      winner    = hit ? idx : winner;
      win_found = win_found | hit;
    end
  end

  // Transaction sequencer; every output is a flop.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      rr_ptr    <= PTR_W'(NUM_REQ - 1);
      hold_cnt  <= 20'd0;
      to_cnt    <= 20'd0;
      gnt       <= '0;
      ack       <= '0;
      err       <= '0;
      i2c_start <= 1'b0;
      i2c_data  <= 24'h0;
      busy      <= 1'b0;
    end else begin
      ack       <= '0;
      err       <= '0;
      i2c_start <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            gnt       <= win_onehot;
            i2c_data  <= slot[winner];
            i2c_start <= 1'b1;
            rr_ptr    <= winner;
            busy      <= 1'b1;
            state     <= ISSUE;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          to_cnt <= 20'd0;
          state  <= WAIT_END;
        end
        WAIT_END: begin
          // Completion wins over a timeout landing on the same cycle.
          if (i2c_end) begin
            ack      <= gnt;
            gnt      <= '0;
            hold_cnt <= soft_rst_wr ? RESET_DLY_CYC : GUARD_CYC;
            state    <= HOLD;
          end else if (to_cnt == TIMEOUT_CYC - 20'd1) begin
            err      <= gnt;
            gnt      <= '0;
            hold_cnt <= GUARD_CYC;
            state    <= HOLD;
          end else begin
            to_cnt <= to_cnt + 20'd1;
          end
        end
        HOLD: begin
          hold_cnt <= hold_cnt - 20'd1;
          if (hold_cnt == 20'd1) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            state <= HOLD;
          end
        end
        default: begin
          gnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_req_arbiter.sv
// Randomised self-checking bench for sccb_req_arbiter; a transaction-level model
// predicts winner, payload, ack/err and the post-transaction idle time.
module tb_sccb_req_arbiter;

  localparam int          N   = 3;
  localparam logic [19:0] G   = 20'd8;
  localparam logic [19:0] RDC = 20'd30;
  localparam logic [19:0] TO  = 20'd60;
  localparam int          NEVER = 9999;

  logic            sys_clk = 1'b0;
  logic            sys_rst_n;
  logic [N-1:0]    req;
  logic [24*N-1:0] req_data;
  logic [N-1:0]    gnt, ack, err;
  logic            i2c_start, i2c_end, busy;
  logic [23:0]     i2c_data;

  int total = 0;
  int bad   = 0;
  int prio[$];
  bit started;

  sccb_req_arbiter #(
    .NUM_REQ(N), .GUARD_CYC(G), .RESET_DLY_CYC(RDC), .TIMEOUT_CYC(TO)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .req(req), .req_data(req_data),
    .gnt(gnt), .ack(ack), .err(err), .i2c_start(i2c_start), .i2c_data(i2c_data),
    .i2c_end(i2c_end), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Priority list: front is highest; the winner and everything ahead of it rotate to the back.
  function automatic int pick(input logic [N-1:0] mask);
    for (int i = 0; i < prio.size(); i++) begin
      if (mask[prio[i]]) begin
        int w;
        w = prio[i];
        repeat (i + 1) prio.push_back(prio.pop_front());
        return w;
      end
    end
    return -1;
  endfunction

  function automatic void model_reset();
    prio.delete();
    for (int i = 0; i < N; i++) prio.push_back(i);
  endfunction

  function automatic logic [23:0] rand_payload();
    logic [23:0] d;
    d = 24'($urandom);
    if ($urandom_range(0, 3) == 0) d[23:8] = 16'h3008;
    return d;
  endfunction

  // lat: cycles after the observed start at which i2c_end is driven (NEVER = no end).
  task automatic run_txn(input logic [N-1:0] mask, input int lat, input bit keep, input bit drop_mid);
    int w, cnt, exp_cnt, hold;
    bit ok_ack;
    logic [23:0] exp_d;
    if (!started) begin
      req = mask;
      tick();
    end
    w = pick(mask);
    exp_d = req_data[w*24 +: 24];
    check("start", i2c_start, 1);
    check("gnt", gnt, 1 << w);
    check("data", i2c_data, exp_d);
    check("busy", busy, 1);
    cnt = 0;
    while (cnt <= int'(TO) + 4 && ack == '0 && err == '0) begin
      i2c_end = (cnt == lat);
      if (drop_mid && cnt == 2) req = '0;
      tick();
      cnt++;
      if (cnt == 1) check("start_pulse", i2c_start, 0);
    end
    i2c_end = 1'b0;
    check("resp_seen", (ack | err) != '0, 1);
    ok_ack  = (lat >= 1 && lat <= int'(TO));
    exp_cnt = ok_ack ? lat + 1 : int'(TO) + 1;
    check("resp_cyc", cnt, exp_cnt);
    check("ack", ack, ok_ack ? (1 << w) : 0);
    check("err", err, ok_ack ? 0 : (1 << w));
    check("gnt_clr", gnt, 0);
    hold = (ok_ack && exp_d[23:8] == 16'h3008 && exp_d[7]) ? int'(RDC) : int'(G);
    if (!keep) req = '0;
    tick();
    check("resp_pulse", ack | err, 0);
    cnt = 1;
    if (keep) begin
      while (!i2c_start && cnt < hold + 8) begin tick(); cnt++; end
      check("gap", cnt, hold + 1);
      started = 1'b1;
    end else begin
      while (busy && cnt < hold + 8) begin tick(); cnt++; end
      check("hold", cnt, hold);
      check("data_hold", i2c_data, exp_d);
      started = 1'b0;
    end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    req       = '0;
    req_data  = '0;
    i2c_end   = 1'b0;
    started   = 1'b0;
    model_reset();
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_ack", ack, 0);
    check("rst_err", err, 0);
    check("rst_start", i2c_start, 0);
    check("rst_data", i2c_data, 0);
    check("rst_busy", busy, 0);
    sys_rst_n = 1'b1;
    tick();

    // Continuous requests from everyone: rotation 0,1,2,0,1,2 with fixed gaps.
    req_data = {24'h300a02, 24'h300b01, 24'h310303};
    req = 3'b111;
    for (int i = 0; i < 6; i++) run_txn(3'b111, 20, i < 5, 1'b0);

    // Single write from requester 0.
    req_data = {24'h0, 24'h0, 24'h310303};
    run_txn(3'b001, 50, 1'b0, 1'b0);

    // Soft reset needs the long delay, a plain 0x3008 write does not.
    req_data = {24'h0, 24'h300882, 24'h0};
    run_txn(3'b010, 5, 1'b0, 1'b0);
    req_data = {24'h0, 24'h300842, 24'h0};
    run_txn(3'b010, 5, 1'b0, 1'b0);

    // Timeout, end on the terminal timeout cycle, and request dropped mid-flight.
    req_data = {24'h300882, 24'h123456, 24'habcdef};
    run_txn(3'b100, NEVER, 1'b0, 1'b0);
    run_txn(3'b011, int'(TO), 1'b0, 1'b0);
    run_txn(3'b111, 10, 1'b0, 1'b1);

    // Spurious end while idle is ignored.
    i2c_end = 1'b1;
    tick();
    i2c_end = 1'b0;
    tick();
    check("spur_busy", busy, 0);
    check("spur_start", i2c_start, 0);
    check("spur_ack", ack, 0);

    // Randomised traffic.
    for (int i = 0; i < 25; i++) begin
      int r, lat;
      req_data = {rand_payload(), rand_payload(), rand_payload()};
      r = $urandom_range(0, 9);
      lat = (r == 0) ? NEVER : (r == 1) ? int'(TO) : $urandom_range(1, 15);
      run_txn(N'($urandom_range(1, 7)), lat, 1'b0, $urandom_range(0, 3) == 0);
    end

    // Asynchronous reset while waiting for the I2C master.
    req_data = {24'h112233, 24'h445566, 24'h778899};
    req = 3'b100;
    tick();
    tick();
    tick();
    #2 sys_rst_n = 1'b0;
    #1;
    check("arst_gnt", gnt, 0);
    check("arst_ack", ack, 0);
    check("arst_err", err, 0);
    check("arst_start", i2c_start, 0);
    check("arst_data", i2c_data, 0);
    check("arst_busy", busy, 0);
    req = '0;
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    model_reset();
    started = 1'b0;
    tick();
    check("arst_idle", busy | (ack != '0) | (err != '0), 0);
    run_txn(3'b111, 7, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
